// File: rtl/mem_burst_pkg.sv
// Shared types and widths for the burst master toward the 128-bit byte-enabled RAM.
package mem_burst_pkg;

   localparam int BEAT_BYTES = 16;
   localparam int DATA_W     = 128;
   localparam int BE_W       = 16;

   typedef enum logic [2:0] {
      IDLE,
      READ,
      READ_DRAIN,
      WRITE,
      DONE
   } state_e;

endpackage

// File: rtl/mem_burst_fifo2.sv
// Two-entry read-beat buffer between the RAM read port and the rd_* stream.
module mem_burst_fifo2
   import mem_burst_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] pop_data,
   output logic              full,
   output logic              empty
);

   logic [DATA_W-1:0] mem_q [2];
   logic [DATA_W-1:0] mem_d [2];
   logic              wr_ptr_q, wr_ptr_d;
   logic              rd_ptr_q, rd_ptr_d;
   logic [1:0]        count_q, count_d;
   logic              do_push, do_pop;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;

      do_pop  = pop & (count_q != 2'd0);
      // A push into a full buffer is only legal when the head leaves in the same cycle.
      do_push = push & ((count_q != 2'd2) | do_pop);

      if (do_push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = ~wr_ptr_q;
      end
      if (do_pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end

      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign pop_data = mem_q[rd_ptr_q];
   assign full     = (count_q == 2'd2);
   assign empty    = (count_q == 2'd0);

endmodule

// File: rtl/mem_burst_master.sv
// Burst master: turns one read/write command into consecutive 16-byte beats on a
// synchronous RAM, streaming write beats in and read beats out through a 2-entry buffer.
module mem_burst_master
   import mem_burst_pkg::*;
#(
   parameter int ADDR_W = 20,
   parameter int LEN_W  = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_address,
   input  logic [LEN_W-1:0]  cmd_length,
   input  logic [BE_W-1:0]   cmd_byte_enablers,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [DATA_W-1:0] wr_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [DATA_W-1:0] rd_data,
   output logic              done,
   output logic [ADDR_W-1:0] ram_address,
   output logic [DATA_W-1:0] ram_data_in,
   output logic [BE_W-1:0]   ram_byte_enablers,
   output logic              ram_write_enable,
   input  logic [DATA_W-1:0] ram_data_out
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;
   logic [BE_W-1:0]   mask_q, mask_d;
   logic              inflight_q, inflight_d;

   logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [1:0]        occupancy, pending;
   logic              issue, last_beat;

   mem_burst_fifo2 u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (fifo_push),
      .push_data (ram_data_out),
      .pop       (fifo_pop),
      .pop_data  (rd_data),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // RAM data appears one cycle after the address, so an issued read lands in the buffer next cycle.
   assign fifo_push = inflight_q;

   always_comb begin
      cmd_ready         = (state_q == IDLE) & ~reset;
      wr_ready          = (state_q == WRITE) & ~reset;
      done              = (state_q == DONE) & ~reset;
      rd_valid          = ~fifo_empty & ~reset;
      fifo_pop          = rd_valid & rd_ready;
      ram_write_enable  = wr_ready & wr_valid;
      ram_byte_enablers = wr_ready ? mask_q : '0;
      ram_data_in       = wr_ready ? wr_data : '0;
      ram_address       = reset ? '0 : addr_q;
   end

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      len_d      = len_q;
      cnt_d      = cnt_q;
      mask_d     = mask_q;
      inflight_d = 1'b0;
      issue      = 1'b0;

      occupancy = fifo_full ? 2'd2 : {1'b0, ~fifo_empty};
      // Entries held next cycle once this pop and the arriving in-flight beat are settled.
      pending   = occupancy - {1'b0, fifo_pop} + {1'b0, inflight_q};
      last_beat = (cnt_q == len_q - LEN_W'(1));

      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               addr_d = cmd_address;
               len_d  = cmd_length;
               mask_d = cmd_byte_enablers;
               cnt_d  = '0;
               if (cmd_length == '0) begin
                  state_d = DONE;
               end else if (cmd_write) begin
                  state_d = WRITE;
               end else begin
                  state_d = READ;
               end
            end
         end

         READ: begin
            if (pending < 2'd2) begin
               issue      = 1'b1;
               inflight_d = 1'b1;
               addr_d     = addr_q + ADDR_W'(BEAT_BYTES);
               cnt_d      = cnt_q + LEN_W'(1);
               if (last_beat) begin
                  state_d = READ_DRAIN;
               end
            end
         end

         READ_DRAIN: begin
            if (fifo_empty && !inflight_q) begin
               state_d = DONE;
            end
         end

         WRITE: begin
            if (wr_valid) begin
               addr_d = addr_q + ADDR_W'(BEAT_BYTES);
               cnt_d  = cnt_q + LEN_W'(1);
               if (last_beat) begin
                  state_d = DONE;
               end
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         len_q      <= '0;
         cnt_q      <= '0;
         mask_q     <= '0;
         inflight_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         len_q      <= len_d;
         cnt_q      <= cnt_d;
         mask_q     <= mask_d;
         inflight_q <= inflight_d;
      end
   end

endmodule

// File: tb/tb_mem_burst_master.sv
// Self-checking bench for mem_burst_master: byte-addressed RAM model, reference memory, directed and random bursts.
module tb_mem_burst_master;

   localparam int unsigned AMASK = 32'h000F_FFFF;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         cmd_valid = 1'b0;
   logic         cmd_ready;
   logic         cmd_write = 1'b0;
   logic [19:0]  cmd_address = '0;
   logic [7:0]   cmd_length = '0;
   logic [15:0]  cmd_byte_enablers = '0;
   logic         wr_valid = 1'b0;
   logic         wr_ready;
   logic [127:0] wr_data = '0;
   logic         rd_valid;
   logic         rd_ready = 1'b0;
   logic [127:0] rd_data;
   logic         done;
   logic [19:0]  ram_address;
   logic [127:0] ram_data_in;
   logic [15:0]  ram_byte_enablers;
   logic         ram_write_enable;
   logic [127:0] ram_data_out;

   mem_burst_master #(
      .ADDR_W (20),
      .LEN_W  (8)
   ) dut (
      .clock             (clock),
      .reset             (reset),
      .cmd_valid         (cmd_valid),
      .cmd_ready         (cmd_ready),
      .cmd_write         (cmd_write),
      .cmd_address       (cmd_address),
      .cmd_length        (cmd_length),
      .cmd_byte_enablers (cmd_byte_enablers),
      .wr_valid          (wr_valid),
      .wr_ready          (wr_ready),
      .wr_data           (wr_data),
      .rd_valid          (rd_valid),
      .rd_ready          (rd_ready),
      .rd_data           (rd_data),
      .done              (done),
      .ram_address       (ram_address),
      .ram_data_in       (ram_data_in),
      .ram_byte_enablers (ram_byte_enablers),
      .ram_write_enable  (ram_write_enable),
      .ram_data_out      (ram_data_out)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] ram     [int unsigned];
   logic [7:0] ref_mem [int unsigned];

   function automatic logic [7:0] init_byte(input int unsigned a);
      return 8'(a * 37 + (a >> 8) + 5);
   endfunction

   function automatic logic [127:0] ram_beat(input int unsigned a);
      logic [127:0] b;
      int unsigned  k;
      for (int i = 0; i < 16; i++) begin
         k = (a + 32'(i)) & AMASK;
         b[8*i +: 8] = ram.exists(k) ? ram[k] : init_byte(k);
      end
      return b;
   endfunction

   function automatic logic [127:0] ref_beat(input int unsigned a);
      logic [127:0] b;
      int unsigned  k;
      for (int i = 0; i < 16; i++) begin
         k = (a + 32'(i)) & AMASK;
         b[8*i +: 8] = ref_mem.exists(k) ? ref_mem[k] : init_byte(k);
      end
      return b;
   endfunction

   // RAM: beat at byte address a covers bytes a..a+15 (wrapping); read data one cycle after the address.
   always @(posedge clock) begin : ram_model
      int unsigned base;
      base = 32'(ram_address);
      ram_data_out <= ram_beat(base);
      if (ram_write_enable) begin
         for (int i = 0; i < 16; i++) begin
            if (ram_byte_enablers[i]) ram[(base + 32'(i)) & AMASK] = ram_data_in[8*i +: 8];
         end
      end
   end

   logic [127:0] rd_log [$];
   int           rdv_cyc_log [$];
   int           w_cyc_log [$];
   logic [19:0]  w_addr_log [$];
   int           done_cyc_log [$];
   int           stall_err = 0;
   logic         pv = 1'b0;
   logic         pr = 1'b0;
   logic [127:0] pd = '0;

   always @(negedge clock) begin
      if (reset) begin
         pv <= 1'b0;
      end else begin
         if (pv && !pr && !(rd_valid && rd_data === pd)) stall_err <= stall_err + 1;
         if (rd_valid) rdv_cyc_log.push_back(cyc);
         if (rd_valid && rd_ready) rd_log.push_back(rd_data);
         if (ram_write_enable) begin
            w_cyc_log.push_back(cyc);
            w_addr_log.push_back(ram_address);
         end
         if (done) done_cyc_log.push_back(cyc);
         pv <= rd_valid;
         pr <= rd_ready;
         pd <= rd_data;
      end
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   int hs_cyc;
   int b_r0, b_v0, b_w0, b_d0;

   task automatic issue_cmd(input bit wr, input logic [19:0] addr, input int len, input logic [15:0] mask);
      int t;
      cmd_valid         = 1'b1;
      cmd_write         = wr;
      cmd_address       = addr;
      cmd_length        = 8'(len);
      cmd_byte_enablers = mask;
      for (t = 0; t < 20; t++) begin
         @(negedge clock);
         if (cmd_ready) break;
      end
      @(posedge clock);
      #1;
      cmd_valid = 1'b0;
      hs_cyc    = cyc;
      chk("cmd_accepted", 128'(t < 20), 128'(1));
   endtask

   task automatic chk_region(input logic [19:0] addr, input int len);
      int unsigned a;
      for (int i = -1; i <= len; i++) begin
         a = (32'(addr) + 32'(16 * i)) & AMASK;
         chk($sformatf("ram_at_%05h", a), ram_beat(a), ref_beat(a));
      end
   endtask

   // mode 0: rd_ready=1 / wr_valid=1; mode 1: rd_ready 1,0,0,1 pattern; mode 2: random.
   task automatic run_burst(input bit wr, input logic [19:0] addr, input int len,
                            input logic [15:0] mask, input int mode, input string tag);
      logic [127:0] wdata [$];
      logic [127:0] exp_rd [$];
      int unsigned  a;
      int           beat, ph, t;
      bit           consumed, got_done;

      b_r0 = rd_log.size();
      b_v0 = rdv_cyc_log.size();
      b_w0 = w_cyc_log.size();
      b_d0 = done_cyc_log.size();

      for (int i = 0; i < len; i++) begin
         wdata.push_back({$urandom, $urandom, $urandom, $urandom});
         a = (32'(addr) + 32'(16 * i)) & AMASK;
         if (wr) begin
            for (int j = 0; j < 16; j++)
               if (mask[j]) ref_mem[(a + 32'(j)) & AMASK] = wdata[i][8*j +: 8];
         end else begin
            exp_rd.push_back(ref_beat(a));
         end
      end

      issue_cmd(wr, addr, len, mask);
      beat = 0;
      ph   = 0;
      for (t = 0; t < 300; t++) begin
         wr_valid = wr && (beat < len) && (mode != 2 || $urandom_range(0, 2) != 0);
         wr_data  = (beat < len) ? wdata[beat] : '0;
         if (mode == 0)      rd_ready = 1'b1;
         else if (mode == 1) rd_ready = (ph % 4 == 0) || (ph % 4 == 3);
         else                rd_ready = 1'($urandom_range(0, 1));
         ph++;
         @(negedge clock);
         consumed = wr_valid & wr_ready;
         got_done = done;
         @(posedge clock);
         #1;
         if (consumed) beat++;
         if (got_done) break;
      end
      wr_valid = 1'b0;
      rd_ready = 1'b0;
      @(negedge clock);
      @(posedge clock);
      #1;

      chk({tag, "_done_once"}, 128'(done_cyc_log.size() - b_d0), 128'(1));
      if (wr) begin
         chk({tag, "_write_count"}, 128'(w_cyc_log.size() - b_w0), 128'(len));
         for (int i = 0; i < len; i++)
            chk($sformatf("%s_waddr%0d", tag, i), 128'(w_addr_log[b_w0 + i]),
                128'((32'(addr) + 32'(16 * i)) & AMASK));
         chk_region(addr, len);
      end else begin
         chk({tag, "_no_write"}, 128'(w_cyc_log.size() - b_w0), 128'(0));
         chk({tag, "_read_count"}, 128'(rd_log.size() - b_r0), 128'(len));
         for (int i = 0; i < len; i++)
            chk($sformatf("%s_rbeat%0d", tag, i), rd_log[b_r0 + i], exp_rd[i]);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin : main
      int base;

      #1;
      chk("rst_cmd_ready", 128'(cmd_ready), 128'(0));
      chk("rst_rd_valid", 128'(rd_valid), 128'(0));
      chk("rst_wr_ready", 128'(wr_ready), 128'(0));
      chk("rst_done", 128'(done), 128'(0));
      chk("rst_ram_we", 128'(ram_write_enable), 128'(0));
      chk("rst_ram_be", 128'(ram_byte_enablers), 128'(0));
      chk("rst_ram_addr", 128'(ram_address), 128'(0));
      chk("rst_ram_din", ram_data_in, 128'(0));
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      chk("idle_cmd_ready", 128'(cmd_ready), 128'(1));
      chk("idle_rd_valid", 128'(rd_valid), 128'(0));
      @(posedge clock);
      #1;

      // Write burst at 0x100, four beats on consecutive cycles, then one done.
      run_burst(1'b1, 20'h00100, 4, 16'hFFFF, 0, "wr4");
      for (int i = 0; i < 4; i++)
         chk($sformatf("wr4_wcyc%0d", i), 128'(w_cyc_log[b_w0 + i]), 128'(hs_cyc + i));
      chk("wr4_done_cyc", 128'(done_cyc_log[b_d0]), 128'(hs_cyc + 4));

      // Read back the same beats: rd_valid first in the third cycle after the handshake edge, back-to-back.
      run_burst(1'b0, 20'h00100, 4, 16'h0000, 0, "rd4");
      chk("rd4_valid_cycles", 128'(rdv_cyc_log.size() - b_v0), 128'(4));
      for (int i = 0; i < 4; i++)
         chk($sformatf("rd4_vcyc%0d", i), 128'(rdv_cyc_log[b_v0 + i]), 128'(hs_cyc + 2 + i));

      // Six-beat read with a stalling consumer.
      run_burst(1'b0, 20'h00400, 6, 16'h0000, 1, "rd6_stall");
      chk("rd6_stall_stable", 128'(stall_err), 128'(0));

      // Unaligned partial write and readback; wrap at the top of the address space.
      run_burst(1'b1, 20'h00005, 2, 16'h000F, 0, "wr_unal");
      run_burst(1'b0, 20'h00005, 2, 16'h0000, 2, "rd_unal");
      run_burst(1'b1, 20'hFFFF0, 2, 16'hA5C3, 0, "wr_wrap");
      run_burst(1'b0, 20'hFFFF0, 2, 16'h0000, 0, "rd_wrap");

      // Zero-length commands complete immediately without touching RAM or the read stream.
      run_burst(1'b1, 20'h00200, 0, 16'hFFFF, 0, "wr_len0");
      chk("wr_len0_done_cyc", 128'(done_cyc_log[b_d0]), 128'(hs_cyc));
      chk("wr_len0_no_rdv", 128'(rdv_cyc_log.size() - b_v0), 128'(0));
      run_burst(1'b0, 20'h00200, 0, 16'h0000, 0, "rd_len0");
      chk("rd_len0_done_cyc", 128'(done_cyc_log[b_d0]), 128'(hs_cyc));
      chk("rd_len0_no_rdv", 128'(rdv_cyc_log.size() - b_v0), 128'(0));

      // Reset during the second beat of a four-beat read.
      issue_cmd(1'b0, 20'h00100, 4, 16'h0000);
      rd_ready = 1'b1;
      for (int t = 0; t < 20; t++) begin
         @(negedge clock);
         if (rd_valid) break;
      end
      @(posedge clock);
      #1;
      reset = 1'b1;
      @(negedge clock);
      chk("abort_rd_valid", 128'(rd_valid), 128'(0));
      chk("abort_done", 128'(done), 128'(0));
      chk("abort_cmd_ready", 128'(cmd_ready), 128'(0));
      chk("abort_ram_addr", 128'(ram_address), 128'(0));
      chk("abort_wr_ready", 128'(wr_ready), 128'(0));
      @(posedge clock);
      #1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      base  = done_cyc_log.size();
      b_v0  = rdv_cyc_log.size();
      @(negedge clock);
      chk("post_rst_cmd_ready", 128'(cmd_ready), 128'(1));
      repeat (5) @(posedge clock);
      #1;
      rd_ready = 1'b0;
      chk("post_rst_no_done", 128'(done_cyc_log.size() - base), 128'(0));
      chk("post_rst_no_rdv", 128'(rdv_cyc_log.size() - b_v0), 128'(0));
      run_burst(1'b0, 20'h00100, 4, 16'h0000, 0, "rd_after_rst");

      // Random bursts against the reference memory.
      for (int n = 0; n < 10; n++) begin
         run_burst(1'($urandom_range(0, 1)), 20'($urandom), int'($urandom_range(1, 7)),
                   16'($urandom), int'($urandom_range(0, 2)), $sformatf("rnd%0d", n));
      end
      chk("final_stall_stable", 128'(stall_err), 128'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
